multi_button_gesture: RTL and testbench

MULTI_BUTTON_GESTURE -- requirements
Module: multi_button_gesture

---
 rtl/multi_button_gesture_if.sv | 25 ++
 rtl/multi_button_gesture.sv | 241 ++++++++++++++++++++++++
 tb/tb_multi_button_gesture.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/multi_button_gesture_if.sv
// rtl/multi_button_gesture_if.sv - gesture event stream with valid/ready handshake
interface multi_button_gesture_if #(
  parameter int NCH = 4
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           evt_valid;
  logic           evt_ready;
  logic [CHW-1:0] evt_ch;
  logic [2:0]     evt_code;

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_code,
    output evt_ready
  );
endinterface

// File: rtl/multi_button_gesture.sv
// rtl/multi_button_gesture.sv - per-channel debounced button gesture detector
// Each channel: sync, debounce, SHORT/LONG/DOUBLE/REPEAT FSM, one-entry slot; round-robin output.
module multi_button_gesture #(
  parameter int NCH      = 4,
  parameter int DEBOUNCE = 500_000,
  parameter int LONG     = 25_000_000,
  parameter int GAP      = 12_500_000,
  parameter int REPEAT   = 5_000_000,
  parameter int CW       = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         button,
  multi_button_gesture_if.master evt,
  output logic [NCH-1:0]         held,
  output logic [NCH-1:0]         ovf
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CW-1:0] DEB_END  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] LONG_END = CW'(LONG - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);
  localparam logic [CW-1:0] REP_END  = CW'(REPEAT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  localparam logic [2:0] CODE_SHORT  = 3'd1;
  localparam logic [2:0] CODE_LONG   = 3'd2;
  localparam logic [2:0] CODE_DOUBLE = 3'd3;
  localparam logic [2:0] CODE_REPEAT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_WAIT2,
    S_PRESS2,
    S_HOLD
  } state_t;

  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sync2_q;
  logic [NCH-1:0] held_q;
  logic [NCH-1:0] ovf_q;
  logic [NCH-1:0] slot_v_q;
  logic [CW-1:0]  deb_cnt_q   [NCH];
  logic [CW-1:0]  timer_q     [NCH];
  state_t         state_q     [NCH];
  logic [2:0]     slot_code_q [NCH];

  logic [NCH-1:0] emit_v;
  logic [2:0]     emit_code [NCH];
  logic [NCH-1:0] take;

  logic           valid_q;
  logic [CHW-1:0] ch_q;
  logic [2:0]     code_q;
  logic [CHW-1:0] last_q;

  logic           load;
  logic           grant_found;
  logic [CHW-1:0] grant_idx;

  // Emission is decoded from the same state/timer compares the FSM uses to leave the state.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      emit_v[i]    = 1'b0;
      emit_code[i] = 3'd0;
      case (state_q[i])
        S_PRESS: begin
          if (held_q[i] && timer_q[i] == LONG_END) begin
            emit_v[i]    = 1'b1;
            emit_code[i] = CODE_LONG;
          end
        end
        S_WAIT2: begin
          if (!held_q[i] && timer_q[i] == GAP_END) begin
            emit_v[i]    = 1'b1;
            emit_code[i] = CODE_SHORT;
          end
        end
        S_PRESS2: begin
          if (!held_q[i]) begin
            emit_v[i]    = 1'b1;
            emit_code[i] = CODE_DOUBLE;
          end
        end
        S_HOLD: begin
          if (held_q[i] && timer_q[i] == REP_END) begin
            emit_v[i]    = 1'b1;
            emit_code[i] = CODE_REPEAT;
          end
        end
        default: ;
      endcase
    end
  end

  assign load = !valid_q || evt.evt_ready;

  // Round-robin: first pending channel above the last grant, else the lowest pending one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!grant_found && slot_v_q[i] && (CHW'(i) > last_q)) begin
        grant_found = 1'b1;
        grant_idx   = CHW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!grant_found && slot_v_q[i]) begin
        grant_found = 1'b1;
        grant_idx   = CHW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      take[i] = load && grant_found && (grant_idx == CHW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      held_q   <= '0;
      ovf_q    <= '0;
      slot_v_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        deb_cnt_q[i]   <= '0;
        timer_q[i]     <= '0;
        state_q[i]     <= S_IDLE;
        slot_code_q[i] <= 3'd0;
      end
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      for (int i = 0; i < NCH; i++) begin
        // Raw level is active-low, so equality with held_q means the two disagree.
        if (sync2_q[i] == held_q[i]) begin
          if (deb_cnt_q[i] == DEB_END) begin
            held_q[i]    <= ~held_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + ONE;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end

        case (state_q[i])
          S_IDLE: begin
            if (held_q[i]) begin
              state_q[i] <= S_PRESS;
              timer_q[i] <= '0;
            end
          end
          S_PRESS: begin
            if (!held_q[i]) begin
              state_q[i] <= S_WAIT2;
              timer_q[i] <= '0;
            end else if (timer_q[i] == LONG_END) begin
              state_q[i] <= S_HOLD;
              timer_q[i] <= '0;
            end else begin
              timer_q[i] <= timer_q[i] + ONE;
            end
          end
          S_WAIT2: begin
            if (held_q[i]) begin
              state_q[i] <= S_PRESS2;
              timer_q[i] <= '0;
            end else if (timer_q[i] == GAP_END) begin
              state_q[i] <= S_IDLE;
              timer_q[i] <= '0;
            end else begin
              timer_q[i] <= timer_q[i] + ONE;
            end
          end
          S_PRESS2: begin
            if (!held_q[i]) begin
              state_q[i] <= S_IDLE;
            end
          end
          S_HOLD: begin
            if (!held_q[i]) begin
              state_q[i] <= S_IDLE;
              timer_q[i] <= '0;
            end else if (timer_q[i] == REP_END) begin
              timer_q[i] <= '0;
            end else begin
              timer_q[i] <= timer_q[i] + ONE;
            end
          end
          default: begin
            state_q[i] <= S_IDLE;
            timer_q[i] <= '0;
          end
        endcase

        // A write wins over a same-cycle transfer; only an untransferred occupant is lost.
        if (emit_v[i]) begin
          slot_v_q[i]    <= 1'b1;
          slot_code_q[i] <= emit_code[i];
          if (slot_v_q[i] && !take[i]) begin
            ovf_q[i] <= 1'b1;
          end
        end else if (take[i]) begin
          slot_v_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      code_q  <= 3'd0;
      last_q  <= CHW'(NCH - 1);
    end else if (load) begin
      if (grant_found) begin
        valid_q <= 1'b1;
        ch_q    <= grant_idx;
        code_q  <= slot_code_q[grant_idx];
        last_q  <= grant_idx;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_ch    = ch_q;
  assign evt.evt_code  = code_q;
  assign held          = held_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_multi_button_gesture.sv
// tb/tb_multi_button_gesture.sv - directed gesture scenarios for multi_button_gesture
module tb_multi_button_gesture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] button = 2'b11;
  logic [1:0] held;
  logic [1:0] ovf;

  multi_button_gesture_if #(.NCH(2)) bus ();

  multi_button_gesture #(
    .NCH(2), .DEBOUNCE(4), .LONG(40), .GAP(20), .REPEAT(10), .CW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button(button),
    .evt(bus),
    .held(held),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int held_cnt = 0;
  int hfall_cyc = 0;
  logic held_prev = 1'b0;
  int ev_ch[$];
  int ev_code[$];
  int ev_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted events are logged on the falling edge before the accepting rising edge.
  always @(negedge clk) begin
    held_cnt  <= held_cnt + (held[0] ? 1 : 0);
    held_prev <= held[0];
    if (held_prev && !held[0]) hfall_cyc <= cyc;
    if (bus.evt_valid && bus.evt_ready) begin
      ev_ch.push_back(int'(bus.evt_ch));
      ev_code.push_back(int'(bus.evt_code));
      ev_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] mask, input int n);
    @(posedge clk);
    #1 button = ~mask;
    repeat (n) @(posedge clk);
    #1 button = 2'b11;
  endtask

  task automatic do_reset();
    button = 2'b11;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    bus.evt_ready = 1'b1;
    button = 2'b11;
    reset = 1'b0;
    idle(2);
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.evt_valid); end
    n_checks++; if (bus.evt_ch !== 1'b0) begin n_fail++; $display("FAIL reset_ch: got %0d expected 0", bus.evt_ch); end
    n_checks++; if (bus.evt_code !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", bus.evt_code); end
    n_checks++; if (held !== 2'b00) begin n_fail++; $display("FAIL reset_held: got %b expected 00", held); end
    n_checks++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL reset_ovf: got %b expected 00", ovf); end
    reset = 1'b1;
    idle(10);
    n_checks++; if (bus.evt_valid !== 1'b0 || held !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle: got valid=%0b held=%b expected 0/00", bus.evt_valid, held); end
  endtask

  task automatic test_short();
    int n0, h0;
    do_reset();
    n0 = ev_ch.size();
    h0 = held_cnt;
    press(2'b01, 15);
    idle(50);
    n_checks++; if (ev_ch.size() - n0 !== 1) begin n_fail++; $display("FAIL short_count: got %0d expected 1", ev_ch.size() - n0); end
    if (ev_ch.size() > n0) begin
      n_checks++; if (ev_ch[n0] !== 0 || ev_code[n0] !== 1) begin n_fail++; $display("FAIL short_event: got ch=%0d code=%0d expected ch=0 code=1", ev_ch[n0], ev_code[n0]); end
      n_checks++; if (ev_cyc[n0] - hfall_cyc !== 22) begin n_fail++; $display("FAIL short_latency: got %0d expected 22", ev_cyc[n0] - hfall_cyc); end
    end
    n_checks++; if (held_cnt - h0 !== 15) begin n_fail++; $display("FAIL short_held_cycles: got %0d expected 15", held_cnt - h0); end
  endtask

  task automatic test_double();
    int n0;
    do_reset();
    n0 = ev_ch.size();
    press(2'b01, 10);
    idle(7);
    press(2'b01, 10);
    idle(50);
    n_checks++; if (ev_ch.size() - n0 !== 1) begin n_fail++; $display("FAIL double_count: got %0d expected 1", ev_ch.size() - n0); end
    if (ev_ch.size() > n0) begin
      n_checks++; if (ev_ch[n0] !== 0 || ev_code[n0] !== 3) begin n_fail++; $display("FAIL double_event: got ch=%0d code=%0d expected ch=0 code=3", ev_ch[n0], ev_code[n0]); end
    end
  endtask

  task automatic test_long_repeat();
    int n0;
    int exp_code[4] = '{2, 4, 4, 4};
    do_reset();
    n0 = ev_ch.size();
    press(2'b10, 80);
    idle(30);
    n_checks++; if (ev_ch.size() - n0 !== 4) begin n_fail++; $display("FAIL long_count: got %0d expected 4", ev_ch.size() - n0); end
    if (ev_ch.size() - n0 >= 4) begin
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (ev_ch[n0+k] !== 1 || ev_code[n0+k] !== exp_code[k]) begin n_fail++; $display("FAIL long_event%0d: got ch=%0d code=%0d expected ch=1 code=%0d", k, ev_ch[n0+k], ev_code[n0+k], exp_code[k]); end
        if (k > 0) begin
          n_checks++; if (ev_cyc[n0+k] - ev_cyc[n0+k-1] !== 10) begin n_fail++; $display("FAIL repeat_spacing%0d: got %0d expected 10", k, ev_cyc[n0+k] - ev_cyc[n0+k-1]); end
        end
      end
    end
  endtask

  task automatic test_glitch();
    int n0, h0;
    do_reset();
    n0 = ev_ch.size();
    h0 = held_cnt;
    for (int r = 0; r < 3; r++) begin
      press(2'b01, 3);
      idle(6);
    end
    idle(40);
    n_checks++; if (held_cnt - h0 !== 0) begin n_fail++; $display("FAIL glitch_held: got %0d expected 0", held_cnt - h0); end
    n_checks++; if (ev_ch.size() - n0 !== 0) begin n_fail++; $display("FAIL glitch_events: got %0d expected 0", ev_ch.size() - n0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    do_reset();
    n0 = ev_ch.size();
    press(2'b11, 48);
    idle(20);
    n_checks++; if (ev_ch.size() - n0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", ev_ch.size() - n0); end
    if (ev_ch.size() - n0 >= 2) begin
      n_checks++; if (ev_ch[n0] !== 0 || ev_code[n0] !== 2) begin n_fail++; $display("FAIL b2b_first: got ch=%0d code=%0d expected ch=0 code=2", ev_ch[n0], ev_code[n0]); end
      n_checks++; if (ev_ch[n0+1] !== 1 || ev_code[n0+1] !== 2) begin n_fail++; $display("FAIL b2b_second: got ch=%0d code=%0d expected ch=1 code=2", ev_ch[n0+1], ev_code[n0+1]); end
      n_checks++; if (ev_cyc[n0+1] - ev_cyc[n0] !== 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 1", ev_cyc[n0+1] - ev_cyc[n0]); end
    end
  endtask

  task automatic test_overflow();
    int n0;
    int exp_ch[3] = '{0, 1, 0};
    int exp_code[3] = '{2, 4, 4};
    do_reset();
    bus.evt_ready = 1'b0;
    n0 = ev_ch.size();
    @(posedge clk);
    #1 button = 2'b00;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (c >= 48) begin
        n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ch !== 1'b0 || bus.evt_code !== 3'd2) begin n_fail++; $display("FAIL stall_stable@%0d: got v=%0b ch=%0d code=%0d expected 1/0/2", c, bus.evt_valid, bus.evt_ch, bus.evt_code); end
      end
      if (c == 50) begin
        n_checks++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL ovf_before: got %b expected 00", ovf); end
      end
      if (c == 58) begin
        n_checks++; if (ovf !== 2'b10) begin n_fail++; $display("FAIL ovf_set: got %b expected 10", ovf); end
        button = 2'b11;
      end
      if (c == 60) bus.evt_ready = 1'b1;
    end
    idle(20);
    n_checks++; if (ev_ch.size() - n0 !== 3) begin n_fail++; $display("FAIL ovf_count: got %0d expected 3", ev_ch.size() - n0); end
    if (ev_ch.size() - n0 >= 3) begin
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (ev_ch[n0+k] !== exp_ch[k] || ev_code[n0+k] !== exp_code[k]) begin n_fail++; $display("FAIL ovf_event%0d: got ch=%0d code=%0d expected ch=%0d code=%0d", k, ev_ch[n0+k], ev_code[n0+k], exp_ch[k], exp_code[k]); end
      end
    end
    n_checks++; if (ovf !== 2'b10) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 10", ovf); end
  endtask

  task automatic test_reset_mid();
    int n1;
    do_reset();
    bus.evt_ready = 1'b0;
    press(2'b10, 10);
    idle(29);
    @(posedge clk);
    #1 button = 2'b10;
    idle(15);
    n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ch !== 1'b1 || bus.evt_code !== 3'd1) begin n_fail++; $display("FAIL mid_pending: got v=%0b ch=%0d code=%0d expected 1/1/1", bus.evt_valid, bus.evt_ch, bus.evt_code); end
    n_checks++; if (held !== 2'b01) begin n_fail++; $display("FAIL mid_held: got %b expected 01", held); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.evt_valid !== 1'b0 || bus.evt_ch !== 1'b0 || bus.evt_code !== 3'd0 || held !== 2'b00 || ovf !== 2'b00) begin n_fail++; $display("FAIL mid_reset_outputs: got v=%0b ch=%0d code=%0d held=%b ovf=%b expected all 0", bus.evt_valid, bus.evt_ch, bus.evt_code, held, ovf); end
    idle(2);
    reset = 1'b1;
    bus.evt_ready = 1'b1;
    n1 = ev_ch.size();
    idle(10);
    n_checks++; if (held[0] !== 1'b1) begin n_fail++; $display("FAIL mid_repress: got %0b expected 1", held[0]); end
    button = 2'b11;
    idle(20);
    n_checks++; if (ev_ch.size() - n1 !== 0) begin n_fail++; $display("FAIL mid_no_event: got %0d expected 0", ev_ch.size() - n1); end
    idle(40);
    n_checks++; if (ev_ch.size() - n1 !== 1) begin n_fail++; $display("FAIL mid_new_count: got %0d expected 1", ev_ch.size() - n1); end
    if (ev_ch.size() > n1) begin
      n_checks++; if (ev_ch[n1] !== 0 || ev_code[n1] !== 1) begin n_fail++; $display("FAIL mid_new_event: got ch=%0d code=%0d expected ch=0 code=1", ev_ch[n1], ev_code[n1]); end
    end
  endtask

  initial begin
    bus.evt_ready = 1'b1;
    test_reset();
    test_short();
    test_double();
    test_long_repeat();
    test_glitch();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
